switch_input_buffer: RTL and testbench
======================================

Name: switch_input_buffer

Overview:
- Per-input-port flit FIFO of the xpipes switch, sitting directly upstream of the output-port allocators.
- Accepts flits from the incoming link under stall/go flow control.
- Presents the head-of-queue flit and its valid to every allocator in parallel.
- Pops the flit only when no allocator reports not-accept for it.
- One instance per switch input; its flit_out/valid_out drive the FLIT_in_k/VALID_in_k inputs of all allocators, and the OR of their per-input not-accept bits returns as nack_in.

Parameters:
- FLIT_W, 80, flit width in bits.
- DEPTH, 4, FIFO entries; power of two, min 2.
- N_OUT, 5, number of allocators (switch output ports) feeding back not-accept.
- FTYPE_W, 2, width of flit-type field at flit[FTYPE_W-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flit_in  in  FLIT_W  incoming link flit.
- valid_in  in  1  incoming flit valid.
- stall_out  out  1  to upstream: do not send; high when FIFO full.
- flit_out  out  FLIT_W  head-of-queue flit to all allocators.
- valid_out  out  1  head-of-queue valid (FIFO non-empty).
- nack_in  in  N_OUT  per-allocator not-accept for this input (BWDAUX1 bit of this input from each allocator).
- overflow  out  1  sticky: a flit arrived while stall_out was high.
- count  out  $clog2(DEPTH)+1  current occupancy.
- pkt_err  out  1  sticky packet-framing error (optional feature only).

Behaviour:
- Storage: DEPTH x FLIT_W register array, read pointer rd_ptr, write pointer wr_ptr, occupancy counter cnt.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - cnt is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset, synchronous on rst=1 at a clk edge:
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - valid_out=0, stall_out=0, overflow=0, pkt_err=0.
  - Array contents are don't-care; flit_out is don't-care while valid_out=0.
  - Reset mid-operation discards all queued flits.
- valid_out = (cnt != 0), combinational from registers.
- flit_out = mem[rd_ptr], with no output register. The allocator sees the new head in the cycle after a pop.
- stall_out = (cnt == DEPTH), from registered cnt only. There is no combinational path from nack_in or valid_in to stall_out.
- push = valid_in & ~stall_out. On push, mem[wr_ptr] <= flit_in and wr_ptr++.
- pop = valid_out & ~|nack_in. On pop, rd_ptr++.
  - Pop is evaluated combinationally in the same cycle as the allocator's not-accept.
  - A flit whose port field matches no allocator gets no nack and is therefore popped (dropped). This is intended: it prevents head-of-line deadlock on a misrouted flit.
- cnt update:
  - push & ~pop: cnt+1.
  - pop & ~push: cnt-1.
  - push & pop: unchanged.
- Full with simultaneous pop: push is still blocked because stall_out is registered; the slot frees next cycle. This costs 1-cycle throughput at full, and is accepted.
- Empty with valid_in: the flit is written; it appears on valid_out next cycle. Minimum latency is 1 cycle.
- No push-while-empty bypass.
- valid_in & stall_out: the flit is ignored and overflow <= 1 (sticky until rst).
- Throughput: 1 flit/cycle sustained when nack_in=0 and cnt<DEPTH.

Optional Feature:
- Macro: SWITCH_INBUF_PKT_CHECK_EN.
- Defined: instantiates a framing checker on pushed flits. It holds an open-packet state bit, reset 0.
  - HEAD with open=0: open <= 1.
  - HEAD with open=1: error.
  - PAYL or TAIL with open=0: error.
  - TAIL with open=1: open <= 0.
  - SING with open=1: error.
  - Any error sets pkt_err (sticky until rst). The flit is still stored unchanged.
- Undefined: no checker logic; pkt_err tied 0.

Decomposition:
- Shared package noc_pkg holds:
  - flit-type encodings ENC_HEAD, ENC_PAYL, ENC_TAIL, ENC_SING;
  - FTYPE_W;
  - port-ID field width (3) and its position directly above the type field;
  - default FLIT_W.
- One sub-module, noc_pkt_checker (state bit plus decode), instantiated only under SWITCH_INBUF_PKT_CHECK_EN.
- FIFO pointer logic stays inline.

Test Plan:
- Reset then single flit: after rst, push HEAD flit 0x..A1 with nack_in=0 → valid_out=1 next cycle with flit_out=0x..A1, popped that cycle, count back to 0.
- Fill: DEPTH=4, nack_in=5'b00100 held, push 5 flits back-to-back → stall_out=1 after 4th push, 5th flit dropped, overflow=1, count=4.
- Drain order: from full, release nack_in=0 → flits pop in FIFO order, one per cycle, with pointer wrap verified over 10 flits; stall_out falls the cycle after the first pop.
- Simultaneous push/pop: cnt=2, valid_in=1, nack_in=0 for 8 cycles → count stays 2 and output order is preserved.
- Rst mid-operation: cnt=3, assert rst one cycle → valid_out=0, count=0, overflow=0 next cycle; previous flits never appear.
- With SWITCH_INBUF_PKT_CHECK_EN: push HEAD, HEAD → pkt_err=1. Separate run pushing HEAD, PAYL, TAIL, SING → pkt_err stays 0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit field widths and flit-type encodings
package noc_pkg;

    localparam int FTYPE_W    = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_LSB   = FTYPE_W;
    localparam int FLIT_W_DEF = 80;

    typedef enum logic [FTYPE_W-1:0] {
        ENC_SING = 2'b00,
        ENC_HEAD = 2'b01,
        ENC_PAYL = 2'b10,
        ENC_TAIL = 2'b11
    } ftype_e;

endpackage

// File: rtl/noc_pkt_checker.sv
// rtl/noc_pkt_checker.sv - packet framing checker on pushed flits, sticky error
module noc_pkt_checker
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [FTYPE_W-1:0] ftype_i,
    output logic               err_o
);

    logic open_q, open_d;
    logic err_q, err_d;

    always_comb begin
        open_d = open_q;
        err_d  = err_q;
        if (push_i) begin
            case (ftype_i)
                ENC_HEAD: begin
                    if (open_q) err_d  = 1'b1;
                    else        open_d = 1'b1;
                end
                ENC_PAYL: begin
                    if (!open_q) err_d = 1'b1;
                end
                ENC_TAIL: begin
                    if (!open_q) err_d  = 1'b1;
                    else         open_d = 1'b0;
                end
                ENC_SING: begin
                    if (open_q) err_d = 1'b1;
                end
                default: err_d = err_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            open_q <= open_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/switch_input_buffer.sv
// rtl/switch_input_buffer.sv - switch input flit FIFO feeding all allocators
// Optional framing checker enabled by SWITCH_INBUF_PKT_CHECK_EN.
module switch_input_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int DEPTH   = 4,
    parameter int N_OUT   = 5,
    parameter int FTYPE_W = noc_pkg::FTYPE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic                     valid_in,
    output logic                     stall_out,
    output logic [FLIT_W-1:0]        flit_out,
    output logic                     valid_out,
    input  logic [N_OUT-1:0]         nack_in,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (FTYPE_W != noc_pkg::FTYPE_W) begin : g_bad_ftype
        $error("FTYPE_W must match the shared flit-type encoding width");
    end

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    assign valid_out = (cnt_q != '0);
    assign stall_out = (cnt_q == CW'(DEPTH));
    assign flit_out  = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign overflow  = overflow_q;

    // A head no allocator claims gets no nack and drains, avoiding head-of-line lockup.
    assign push = valid_in & ~stall_out;
    assign pop  = valid_out & ~|nack_in;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (valid_in & stall_out);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_in;
    end

`ifdef SWITCH_INBUF_PKT_CHECK_EN
    noc_pkt_checker u_pkt_checker (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .ftype_i (flit_in[FTYPE_W-1:0]),
        .err_o   (pkt_err)
    );
`else
    assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_buffer.sv
// tb/tb_switch_input_buffer.sv - queue-model checked bench for switch_input_buffer
module tb_switch_input_buffer;
    import noc_pkg::*;

    localparam int FLIT_W = 80;
    localparam int DEPTH  = 4;
    localparam int N_OUT  = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLIT_W-1:0] flit_in;
    logic              valid_in;
    logic              stall_out;
    logic [FLIT_W-1:0] flit_out;
    logic              valid_out;
    logic [N_OUT-1:0]  nack_in;
    logic              overflow;
    logic [CW-1:0]     count;
    logic              pkt_err;

    switch_input_buffer #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .N_OUT  (N_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flit_in   (flit_in),
        .valid_in  (valid_in),
        .stall_out (stall_out),
        .flit_out  (flit_out),
        .valid_out (valid_out),
        .nack_in   (nack_in),
        .overflow  (overflow),
        .count     (count),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [FLIT_W-1:0] mq[$];
    bit m_ovf, m_err, m_open;

    task automatic chk(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("valid_out", FLIT_W'(valid_out), FLIT_W'(mq.size() != 0));
        if (mq.size() != 0) chk("flit_out", flit_out, mq[0]);
        chk("stall_out", FLIT_W'(stall_out), FLIT_W'(mq.size() == DEPTH));
        chk("count", FLIT_W'(count), FLIT_W'(mq.size()));
        chk("overflow", FLIT_W'(overflow), FLIT_W'(m_ovf));
        chk("pkt_err", FLIT_W'(pkt_err), FLIT_W'(m_err));
    endtask

    // Drive one cycle at the falling edge, advance the model, check at the next falling edge.
    task automatic step(input bit v, input logic [FLIT_W-1:0] f, input logic [N_OUT-1:0] n, input bit r);
        bit full, do_push, do_pop;
        logic [FTYPE_W-1:0] ft;
        rst = r; valid_in = v; flit_in = f; nack_in = n;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_err = 0; m_open = 0;
        end else begin
            full    = (mq.size() == DEPTH);
            do_push = v && !full;
            do_pop  = (mq.size() != 0) && (n == '0);
            if (v && full) m_ovf = 1;
`ifdef SWITCH_INBUF_PKT_CHECK_EN
            if (do_push) begin
                ft = f[FTYPE_W-1:0];
                if (ft == ENC_HEAD) begin
                    if (m_open) m_err = 1; else m_open = 1;
                end else if (ft == ENC_PAYL) begin
                    if (!m_open) m_err = 1;
                end else if (ft == ENC_TAIL) begin
                    if (!m_open) m_err = 1; else m_open = 0;
                end else begin
                    if (m_open) m_err = 1;
                end
            end
`else
            ft = '0;
`endif
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(f);
        end
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    function automatic logic [FLIT_W-1:0] rnd_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[FLIT_W-1:0];
    endfunction

    function automatic logic [FLIT_W-1:0] typed(input logic [FLIT_W-1:0] base, input logic [FTYPE_W-1:0] t);
        logic [FLIT_W-1:0] x;
        x = base;
        x[FTYPE_W-1:0] = t;
        return x;
    endfunction

    initial begin
        logic [FLIT_W-1:0] f;
        logic [N_OUT-1:0]  n;
        rst = 1'b1; valid_in = 1'b0; flit_in = '0; nack_in = '0;
        @(negedge clk);

        // Reset state
        step(0, '0, '0, 1);
        step(0, '0, '0, 1);
        chk("reset_count", FLIT_W'(count), '0);
        chk("reset_valid", FLIT_W'(valid_out), '0);
        chk("reset_stall", FLIT_W'(stall_out), '0);
        chk("reset_ovf",   FLIT_W'(overflow), '0);

        // Single flit: visible one cycle later, popped in that cycle
        step(1, 80'hA1, '0, 0);
        chk("single_valid", FLIT_W'(valid_out), 1);
        chk("single_flit", flit_out, 80'hA1);
        step(0, '0, '0, 0);
        chk("single_drained", FLIT_W'(count), '0);

        // Fill with one allocator refusing, 5th flit overflows
        step(0, '0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, typed(80'h100 + FLIT_W'(i << 4), ENC_PAYL), 5'b00100, 0);
            if (i == 3) chk("fill_stall_after_4", FLIT_W'(stall_out), 1);
        end
        chk("fill_count", FLIT_W'(count), 4);
        chk("fill_overflow", FLIT_W'(overflow), 1);
        chk("fill_head", flit_out, typed(80'h100, ENC_PAYL));

        // Drain with fresh arrivals: pointers wrap over 10 flits
        for (int i = 0; i < 10; i++) begin
            step(1, typed(80'h200 + FLIT_W'(i << 4), ENC_PAYL), '0, 0);
            if (i == 0) chk("drain_stall_falls", FLIT_W'(stall_out), 0);
        end

        // Simultaneous push/pop at occupancy 2
        step(0, '0, '0, 1);
        step(1, typed(80'h300, ENC_SING), 5'b00001, 0);
        step(1, typed(80'h310, ENC_SING), 5'b00001, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, typed(80'h320 + FLIT_W'(i << 4), ENC_SING), '0, 0);
            chk("pushpop_count", FLIT_W'(count), 2);
        end

        // Reset mid-operation discards queued flits
        step(0, '0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, typed(80'h400 + FLIT_W'(i << 4), ENC_SING), 5'b10000, 0);
        step(1, '0, 5'b10000, 0);
        step(1, '0, 5'b10000, 0);
        chk("midrst_pre_ovf", FLIT_W'(overflow), 1);
        step(0, '0, '0, 1);
        chk("midrst_valid", FLIT_W'(valid_out), 0);
        chk("midrst_count", FLIT_W'(count), 0);
        chk("midrst_ovf", FLIT_W'(overflow), 0);
        step(1, typed(80'h500, ENC_SING), '1, 0);
        chk("midrst_new_head", flit_out, typed(80'h500, ENC_SING));

`ifdef SWITCH_INBUF_PKT_CHECK_EN
        step(0, '0, '0, 1);
        step(1, typed(80'h600, ENC_HEAD), '0, 0);
        step(1, typed(80'h610, ENC_HEAD), '0, 0);
        chk("pkt_head_head", FLIT_W'(pkt_err), 1);
        step(0, '0, '0, 1);
        step(1, typed(80'h700, ENC_HEAD), '0, 0);
        step(1, typed(80'h710, ENC_PAYL), '0, 0);
        step(1, typed(80'h720, ENC_TAIL), '0, 0);
        step(1, typed(80'h730, ENC_SING), '0, 0);
        chk("pkt_clean", FLIT_W'(pkt_err), 0);
`endif

        // Randomized traffic
        step(0, '0, '0, 1);
        for (int i = 0; i < 3000; i++) begin
            f = rnd_flit();
            n = ($urandom_range(0, 2) == 0) ? N_OUT'($urandom) : '0;
            step($urandom_range(0, 3) != 0, f, n, $urandom_range(0, 249) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
